// File: rtl/adam_aes_pkg.sv
// ============================================================================
// adam_aes_pkg : shared types for the AES-128 round controller
// Revision 1.0
// ============================================================================
`default_nettype none

package adam_aes_pkg;

    localparam int AES_128_ROUNDS = 10;

    typedef logic [3:0] round_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_KEXP_START = 3'd1,
        ST_KEXP_WAIT  = 3'd2,
        ST_ROUND0     = 3'd3,
        ST_ROUNDS     = 3'd4,
        ST_FINAL      = 3'd5,
        ST_RESP       = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/adam_aes_key_cache.sv
// ============================================================================
// adam_aes_key_cache : single-entry store of the last expanded AES-128 key
// Revision 1.0
// ============================================================================
`default_nettype none

module adam_aes_key_cache
    import adam_aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         store,
    input  logic         clear,
    input  logic [127:0] store_key,
    input  logic [127:0] lookup_key,
    output logic         hit
);

    logic [127:0] key_q;
    logic         valid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_q   <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (store) begin
            key_q   <= store_key;
            valid_q <= 1'b1;
        end
    end

    assign hit = valid_q && (key_q == lookup_key);

endmodule

`default_nettype wire

// File: rtl/adam_aes_round_ctrl.sv
// ============================================================================
// adam_aes_round_ctrl : sequences key expansion and the ten AES-128 rounds.
// Optional key cache enabled by defining ADAM_AES_KEY_CACHE_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module adam_aes_round_ctrl
    import adam_aes_pkg::*;
#(
    parameter int KEXP_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_key,
    input  logic [127:0] req_block,
    output logic         kexp_init,
    output logic [255:0] kexp_key,
    output logic         kexp_keylen,
    input  logic         kexp_ready,
    output logic         rnd_load,
    output logic         rnd_step,
    output logic         rnd_final,
    output logic [3:0]   rnd_key_idx,
    output logic [127:0] rnd_block,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_err,
    output logic         busy
);

    localparam int CNT_W = (KEXP_TIMEOUT > 1) ? $clog2(KEXP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEXP_TIMEOUT - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    round_idx_t       idx, idx_nx;
    logic [127:0]     key_q, block_q;
    logic             err_q, err_nx;
    logic             accept;
    logic             hit;

    assign accept      = req_valid && (state == ST_IDLE);
    assign kexp_key    = {key_q, 128'h0};
    assign kexp_keylen = 1'b0;
    assign rnd_block   = block_q;

`ifdef ADAM_AES_KEY_CACHE_EN
    // Lookup uses the incoming key so a hit can bypass expansion at accept.
    adam_aes_key_cache u_key_cache (
        .clk        (clk),
        .reset_n    (reset_n),
        .store      ((state == ST_KEXP_WAIT) && kexp_ready),
        .clear      ((state == ST_KEXP_WAIT) && !kexp_ready && (cnt == CNT_LAST)),
        .store_key  (key_q),
        .lookup_key (req_key),
        .hit        (hit)
    );
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            key_q   <= '0;
            block_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            err_q <= err_nx;
            cnt   <= (state == ST_KEXP_WAIT) ? cnt + CNT_W'(1) : '0;
            if (accept) begin
                key_q   <= req_key;
                block_q <= req_block;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        err_nx      = err_q;
        req_ready   = 1'b0;
        kexp_init   = 1'b0;
        rnd_load    = 1'b0;
        rnd_step    = 1'b0;
        rnd_final   = 1'b0;
        rnd_key_idx = '0;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = hit ? ST_ROUND0 : ST_KEXP_START;
                    err_nx   = 1'b0;
                end
            end
            ST_KEXP_START: begin
                kexp_init = 1'b1;
                state_nx  = ST_KEXP_WAIT;
            end
            ST_KEXP_WAIT: begin
                // A done pulse on the final counted cycle still wins over timeout.
                if (kexp_ready) begin
                    state_nx = ST_ROUND0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ST_RESP;
                    err_nx   = 1'b1;
                end
            end
            ST_ROUND0: begin
                rnd_load = 1'b1;
                idx_nx   = round_idx_t'(1);
                state_nx = ST_ROUNDS;
            end
            ST_ROUNDS: begin
                rnd_step    = 1'b1;
                rnd_key_idx = idx;
                idx_nx      = idx + round_idx_t'(1);
                if (idx == round_idx_t'(AES_128_ROUNDS - 1)) begin
                    state_nx = ST_FINAL;
                end
            end
            ST_FINAL: begin
                rnd_step    = 1'b1;
                rnd_final   = 1'b1;
                rnd_key_idx = round_idx_t'(AES_128_ROUNDS);
                idx_nx      = '0;
                err_nx      = 1'b0;
                state_nx    = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (rsp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_adam_aes_round_ctrl.sv
// ============================================================================
// tb_adam_aes_round_ctrl : randomized transaction-level check of the controller
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_adam_aes_round_ctrl;

    localparam int TO     = 64;
    localparam int CYCLES = 6000;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_key;
    logic [127:0] req_block;
    logic         kexp_init;
    logic [255:0] kexp_key;
    logic         kexp_keylen;
    logic         kexp_ready;
    logic         rnd_load;
    logic         rnd_step;
    logic         rnd_final;
    logic [3:0]   rnd_key_idx;
    logic [127:0] rnd_block;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_err;
    logic         busy;

    always #5 clk = ~clk;

    adam_aes_round_ctrl #(.KEXP_TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_key     (req_key),
        .req_block   (req_block),
        .kexp_init   (kexp_init),
        .kexp_key    (kexp_key),
        .kexp_keylen (kexp_keylen),
        .kexp_ready  (kexp_ready),
        .rnd_load    (rnd_load),
        .rnd_step    (rnd_step),
        .rnd_final   (rnd_final),
        .rnd_key_idx (rnd_key_idx),
        .rnd_block   (rnd_block),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    // One expected cycle of controller behaviour; wt marks an expansion-wait
    // cycle and kr tells the bench to deliver the expansion-done pulse there.
    typedef struct packed {
        logic       rdy, init, load, step, fin;
        logic [3:0] idx;
        logic       rv, err, wt, kr;
    } exp_t;

    exp_t         sched[$];
    bit           in_txn, txn_err;
    logic [127:0] cap_key, cap_block, cache_key;
    bit           cache_v;
    int           n_vec = 0, n_bad = 0;

    localparam logic [127:0] K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B0 = 128'h3243f6a8885a308d313198a2e0370734;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(logic rdy, logic init, logic load, logic step, logic fin,
                                int idx, logic rv, logic err, logic wt, logic kr);
        exp_t r;
        r.rdy = rdy; r.init = init; r.load = load; r.step = step; r.fin = fin;
        r.idx = 4'(idx); r.rv = rv; r.err = err; r.wt = wt; r.kr = kr;
        return r;
    endfunction

    // Whole-transaction expectation: optional expansion, then load + 10 rounds.
    task automatic build(input bit hit, input int d);
        in_txn  = 1'b1;
        txn_err = 1'b0;
        if (!hit) begin
            sched.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            if (d >= TO) begin
                for (int i = 0; i < TO; i++) sched.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
                txn_err = 1'b1;
                cache_v = 1'b0;
                return;
            end
            for (int i = 0; i <= d; i++) sched.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, (i == d)));
        end
        sched.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 9; k++) sched.push_back(mk(0, 0, 0, 1, 0, k, 0, 0, 0, 0));
        sched.push_back(mk(0, 0, 0, 1, 1, 10, 0, 0, 0, 0));
    endtask

    initial begin
        exp_t         e;
        int           cyc, txn, resp_left, acc_cyc, lat, n_init, d;
        bit           do_rst, rst5_done, post_rst5, hit;
        logic [127:0] key, last_key, blk;

        reset_n = 1'b0; req_valid = 1'b0; req_key = '0; req_block = '0;
        kexp_ready = 1'b0; rsp_ready = 1'b0;
        in_txn = 0; txn_err = 0; cap_key = '0; cap_block = '0; cache_key = '0; cache_v = 0;
        txn = 0; resp_left = -1; acc_cyc = 0; lat = -1; n_init = 0;
        rst5_done = 0; post_rst5 = 0; last_key = K0;
        repeat (2) @(negedge clk);

        for (cyc = 0; cyc < CYCLES; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (sched.size() > 0)  e = sched.pop_front();
            else if (in_txn)       e = mk(0, 0, 0, 0, 0, 0, 1, txn_err, 0, 0);
            else                   e = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

            if (cyc == 0) begin
                check("reset_req_ready", 256'(req_ready), 256'(1));
                check("reset_kexp_key", kexp_key, 256'h0);
            end
            if (post_rst5) begin
                check("rst5_strobes", 256'({rnd_load, rnd_step, rnd_final, rsp_valid, busy}), 256'(0));
                post_rst5 = 0;
            end

            check("req_ready",   256'(req_ready),   256'(e.rdy));
            check("busy",        256'(busy),        256'(!e.rdy));
            check("kexp_init",   256'(kexp_init),   256'(e.init));
            check("rnd_load",    256'(rnd_load),    256'(e.load));
            check("rnd_step",    256'(rnd_step),    256'(e.step));
            check("rnd_final",   256'(rnd_final),   256'(e.fin));
            check("rnd_key_idx", 256'(rnd_key_idx), 256'(e.idx));
            check("rsp_valid",   256'(rsp_valid),   256'(e.rv));
            check("rsp_err",     256'(rsp_err),     256'(e.err));
            check("kexp_keylen", 256'(kexp_keylen), 256'(0));
            check("kexp_key",    kexp_key,          {cap_key, 128'h0});
            check("rnd_block",   256'(rnd_block),   256'(cap_block));

            if (kexp_init) n_init++;
            if (rsp_valid && lat < 0) lat = cyc - acc_cyc;

            // Background stimulus that the controller must ignore.
            req_valid  = ($urandom_range(0, 3) == 0);
            req_key    = {$urandom, $urandom, $urandom, $urandom};
            req_block  = {$urandom, $urandom, $urandom, $urandom};
            rsp_ready  = $urandom_range(0, 1);
            kexp_ready = e.wt ? e.kr : ($urandom_range(0, 7) == 0);
            reset_n    = 1'b1;

            do_rst = (txn >= 4) && ((e.step && e.idx == 4'd5 && !rst5_done) || ($urandom_range(0, 499) == 0));
            if (do_rst && e.step && e.idx == 4'd5 && !rst5_done) begin
                rst5_done = 1;
                post_rst5 = 1;
            end

            if (e.rv) begin
                if (resp_left < 0) resp_left = (txn == 1) ? 20 : $urandom_range(0, 3);
                rsp_ready = (resp_left == 0);
                if (rsp_ready && !do_rst) begin
                    in_txn    = 1'b0;
                    resp_left = -1;
                    case (txn)
                        1: begin
                            check("t0_latency", 256'(lat), 256'(17));
                            check("t0_inits", 256'(n_init), 256'(1));
                            check("t0_kexp_key_lit", kexp_key, {K0, 128'h0});
                            check("t0_block_lit", 256'(rnd_block), 256'(B0));
                        end
                        2: begin
`ifdef ADAM_AES_KEY_CACHE_EN
                            check("t1_hit_latency", 256'(lat), 256'(12));
                            check("t1_hit_inits", 256'(n_init), 256'(0));
`else
                            check("t1_latency", 256'(lat), 256'(17));
                            check("t1_inits", 256'(n_init), 256'(1));
`endif
                        end
                        3: begin
                            check("t2_timeout_latency", 256'(lat), 256'(66));
                            check("t2_timeout_err", 256'(rsp_err), 256'(1));
                        end
                        4: check("t3_reexpand_inits", 256'(n_init), 256'(1));
                        default: ;
                    endcase
                end else begin
                    resp_left--;
                end
            end

            if (e.rdy && !do_rst) begin
                if (txn < 4) req_valid = 1'b1;
                if (req_valid) begin
                    if (txn < 4)                         key = K0;
                    else if ($urandom_range(0, 1) == 0)  key = last_key;
                    else                                 key = {$urandom, $urandom, $urandom, $urandom};
                    blk = (txn == 0) ? B0 : req_block;
                    case (txn)
                        0, 1:    d = 3;
                        2:       d = TO;
                        3:       d = 5;
                        default: begin
                            case ($urandom_range(0, 9))
                                6, 7:    d = $urandom_range(55, TO - 1);
                                8:       d = TO;
                                default: d = $urandom_range(0, 6);
                            endcase
                        end
                    endcase
`ifdef ADAM_AES_KEY_CACHE_EN
                    hit = cache_v && (cache_key == key);
`else
                    hit = 1'b0;
`endif
                    req_key   = key;
                    req_block = blk;
                    build(hit, d);
                    cap_key   = key;
                    cap_block = blk;
                    last_key  = key;
                    acc_cyc   = cyc;
                    lat       = -1;
                    n_init    = 0;
                    txn++;
                end
            end

            if (e.kr) begin
                cache_key = cap_key;
                cache_v   = 1'b1;
            end
            if (do_rst) begin
                reset_n = 1'b0;
                sched.delete();
                in_txn    = 1'b0;
                resp_left = -1;
                cache_v   = 1'b0;
                cap_key   = '0;
                cap_block = '0;
            end
        end

        if (txn < 5) begin
            n_vec++;
            n_bad++;
            $display("FAIL txn_count: got %0d expected at least 5", txn);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
